// File: rtl/rx_fifo_ctrl_pkg.sv
// rtl/rx_fifo_ctrl_pkg.sv - shared FIFO-controller state encoding and default widths
package rx_fifo_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    WR     = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/rx_fifo_ctrl_if.sv
// rtl/rx_fifo_ctrl_if.sv - receiver, FIFO and status signals of the RX FIFO controller
interface rx_fifo_ctrl_if
  import rx_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_din;
  logic              overrun;
  logic              overrun_clr;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  ferr_cnt;

  modport master (
    output rx_data, rx_valid, rx_frame_err, fifo_full, overrun_clr,
    input  fifo_wr, fifo_din, overrun, drop_cnt, ferr_cnt
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_err, fifo_full, overrun_clr,
    output fifo_wr, fifo_din, overrun, drop_cnt, ferr_cnt
  );

endinterface

// File: rtl/rx_fifo_ctrl_sat_counter.sv
// rtl/rx_fifo_ctrl_sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter
  import rx_fifo_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_fifo_ctrl.sv
// rtl/rx_fifo_ctrl.sv - RX byte hold register, FIFO write sequencer, overrun/drop tracking
// Optional frame-error discard: RX_FIFO_CTRL_FERR_DROP_EN
module rx_fifo_ctrl
  import rx_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  rx_fifo_ctrl_if.slave  bus
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] hold_data, hold_data_nx;
  logic              hold_valid, hold_valid_nx;
  logic              fifo_wr_q, fifo_wr_nx;
  logic [DATA_W-1:0] fifo_din_q, fifo_din_nx;
  logic              overrun_q, overrun_nx;
  logic              accept, emptying, load, drop;

`ifdef RX_FIFO_CTRL_FERR_DROP_EN
  logic ferr_inc;
  assign ferr_inc = bus.rx_valid & bus.rx_frame_err;
  assign accept   = bus.rx_valid & ~bus.rx_frame_err;

  sat_counter #(.CNT_W(CNT_W)) u_ferr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ferr_inc),
    .q     (bus.ferr_cnt)
  );
`else
  assign accept       = bus.rx_valid;
  assign bus.ferr_cnt = '0;
`endif

  // Hold may take a new byte in the same cycle it drains into the FIFO.
  assign emptying = (state == PEND) && !bus.fifo_full;
  assign load     = accept && (!hold_valid || emptying);
  assign drop     = accept && hold_valid && !emptying;

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .q     (bus.drop_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_din_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_data  <= hold_data_nx;
      hold_valid <= hold_valid_nx;
      fifo_wr_q  <= fifo_wr_nx;
      fifo_din_q <= fifo_din_nx;
      overrun_q  <= overrun_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    hold_data_nx  = hold_data;
    hold_valid_nx = hold_valid;
    fifo_wr_nx    = 1'b0;
    fifo_din_nx   = fifo_din_q;
    overrun_nx    = overrun_q;

    if (emptying) begin
      fifo_wr_nx    = 1'b1;
      fifo_din_nx   = hold_data;
      hold_valid_nx = 1'b0;
    end
    if (load) begin
      hold_data_nx  = bus.rx_data;
      hold_valid_nx = 1'b1;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      overrun_nx = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_nx = 1'b0;
    end

    case (state)
      IDLE:    if (load) state_nx = PEND;
      PEND:    if (emptying) state_nx = WR;
      WR:      state_nx = SETTLE;
      SETTLE:  state_nx = hold_valid_nx ? PEND : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.fifo_wr  = fifo_wr_q;
  assign bus.fifo_din = fifo_din_q;
  assign bus.overrun  = overrun_q;

endmodule
